// File: rtl/fir_mdc_job_sched.sv
// Job scheduler for the FIR MDC engine: queues {len, coeff} descriptors, runs them one
// at a time with a clear/start sequence, counts output beats and aborts stalled jobs.
module fir_mdc_job_sched #(
    parameter int COEFF_W     = 32,
    parameter int CNT_W       = 32,
    parameter int QUEUE_DEPTH = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 clear_i,
    input  logic                 trig_i,
    output logic                 trig_ready_o,
    input  logic [CNT_W-1:0]     job_len_i,
    input  logic [4*COEFF_W-1:0] job_coeff_i,
    output logic [4*COEFF_W-1:0] eng_coeff_o,
    output logic                 eng_clear_o,
    output logic                 eng_start_o,
    input  logic                 eng_ready_i,
    input  logic                 out_valid_i,
    input  logic                 out_ready_i,
    output logic                 busy_o,
    output logic                 evt_o,
    output logic                 err_timeout_o,
    output logic [CNT_W-1:0]     beat_cnt_o,
    output logic [CNT_W-1:0]     jobs_done_o
);

    localparam int PTR_W  = $clog2(QUEUE_DEPTH);
    localparam int QCNT_W = PTR_W + 1;
    localparam int WD_W   = $clog2(TIMEOUT + 1);
    localparam int ENT_W  = CNT_W + 4 * COEFF_W;

    localparam logic [QCNT_W-1:0] Q_FULL  = QCNT_W'(QUEUE_DEPTH);
    localparam logic [WD_W-1:0]   WD_LAST = WD_W'(TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_RUN   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;
    localparam logic [2:0] ST_ABORT = 3'd5;

    logic [2:0]           state_r, state_nx_s;
    logic [ENT_W-1:0]     q_mem_r [QUEUE_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r;
    logic [QCNT_W-1:0]    q_cnt_r, q_cnt_nx_s;
    logic                 push_s, pop_s, hs_s;
    logic [ENT_W-1:0]     head_s;
    logic [CNT_W-1:0]     beat_inc_s, target_r, beat_cnt_r, jobs_done_r;
    logic [WD_W-1:0]      wd_r;
    logic [4*COEFF_W-1:0] eng_coeff_r;
    logic                 trig_ready_r, busy_r, evt_r, err_r, eng_clear_r, eng_start_r;

    // Queue handshakes, occupancy and FSM next-state decode
    always_comb begin
        push_s     = trig_i & trig_ready_r;
        pop_s      = (state_r == ST_IDLE) && (q_cnt_r != {QCNT_W{1'b0}}) && eng_ready_i;
        hs_s       = out_valid_i & out_ready_i;
        head_s     = q_mem_r[rd_ptr_r];
        beat_inc_s = beat_cnt_r + CNT_W'(1);
        q_cnt_nx_s = q_cnt_r;
        if (push_s && !pop_s) begin
            q_cnt_nx_s = q_cnt_r + QCNT_W'(1);
        end else if (!push_s && pop_s) begin
            q_cnt_nx_s = q_cnt_r - QCNT_W'(1);
        end else begin
            q_cnt_nx_s = q_cnt_r;
        end
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE:  state_nx_s = pop_s ? ST_LOAD : ST_IDLE;
            ST_LOAD:  state_nx_s = (target_r == {CNT_W{1'b0}}) ? ST_DONE : ST_START;
            ST_START: state_nx_s = ST_RUN;
            ST_RUN: begin
                if (hs_s) begin
                    state_nx_s = (beat_inc_s == target_r) ? ST_DONE : ST_RUN;
                end else if (wd_r == WD_LAST) begin
                    state_nx_s = ST_ABORT;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_DONE:  state_nx_s = ST_IDLE;
            ST_ABORT: state_nx_s = ST_IDLE;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // Descriptor storage; contents are don't-care once popped, so clear only moves pointers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) q_mem_r[i] <= {ENT_W{1'b0}};
        end else if (push_s && !clear_i) begin
            q_mem_r[wr_ptr_r] <= {job_len_i, job_coeff_i};
        end else begin
            q_mem_r <= q_mem_r;
        end
    end

    // Sequencer state, counters and registered pulse outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i || clear_i) begin
            state_r      <= ST_IDLE;
            wr_ptr_r     <= {PTR_W{1'b0}};
            rd_ptr_r     <= {PTR_W{1'b0}};
            q_cnt_r      <= {QCNT_W{1'b0}};
            target_r     <= {CNT_W{1'b0}};
            beat_cnt_r   <= {CNT_W{1'b0}};
            jobs_done_r  <= {CNT_W{1'b0}};
            wd_r         <= {WD_W{1'b0}};
            eng_coeff_r  <= {(4*COEFF_W){1'b0}};
            trig_ready_r <= 1'b1;
            busy_r       <= 1'b0;
            evt_r        <= 1'b0;
            err_r        <= 1'b0;
            eng_clear_r  <= 1'b0;
            eng_start_r  <= 1'b0;
        end else begin
            state_r      <= state_nx_s;
            q_cnt_r      <= q_cnt_nx_s;
            trig_ready_r <= (q_cnt_nx_s != Q_FULL);
            busy_r       <= (state_nx_s != ST_IDLE) || (q_cnt_nx_s != {QCNT_W{1'b0}});
            evt_r        <= (state_nx_s == ST_DONE) || (state_nx_s == ST_ABORT);
            eng_clear_r  <= pop_s || (state_nx_s == ST_ABORT);
            eng_start_r  <= (state_nx_s == ST_START);
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            else        wr_ptr_r <= wr_ptr_r;
            if (pop_s) begin
                rd_ptr_r    <= rd_ptr_r + PTR_W'(1);
                eng_coeff_r <= head_s[4*COEFF_W-1:0];
                target_r    <= head_s[ENT_W-1:4*COEFF_W];
                beat_cnt_r  <= {CNT_W{1'b0}};
                wd_r        <= {WD_W{1'b0}};
            end else if (state_r == ST_RUN) begin
                if (hs_s) begin
                    beat_cnt_r <= beat_inc_s;
                    wd_r       <= {WD_W{1'b0}};
                end else begin
                    wd_r       <= wd_r + WD_W'(1);
                end
            end else begin
                wd_r <= wd_r;
            end
            if (state_nx_s == ST_DONE) jobs_done_r <= jobs_done_r + CNT_W'(1);
            else                       jobs_done_r <= jobs_done_r;
            if (state_nx_s == ST_ABORT) err_r <= 1'b1;
            else                        err_r <= err_r;
        end
    end

    // The engine must also see a flush in the very cycle it is requested
    assign eng_clear_o   = eng_clear_r | clear_i;
    assign eng_start_o   = eng_start_r;
    assign eng_coeff_o   = eng_coeff_r;
    assign trig_ready_o  = trig_ready_r;
    assign busy_o        = busy_r;
    assign evt_o         = evt_r;
    assign err_timeout_o = err_r;
    assign beat_cnt_o    = beat_cnt_r;
    assign jobs_done_o   = jobs_done_r;

endmodule

// File: tb/tb_fir_mdc_job_sched.sv
// Directed bench for fir_mdc_job_sched: a cycle table for the single/zero-length jobs,
// then hand sequences for queue fill, watchdog boundary, abort, clear and async reset.
module tb_fir_mdc_job_sched;

    logic         clk_i = 1'b0;
    logic         rst_i, clear_i, trig_i, eng_ready_i, out_valid_i, out_ready_i;
    logic         trig_ready_o, eng_clear_o, eng_start_o, busy_o, evt_o, err_timeout_o;
    logic [31:0]  job_len_i, beat_cnt_o, jobs_done_o;
    logic [127:0] job_coeff_i, eng_coeff_o;

    int total = 0;
    int bad   = 0;

    localparam logic [127:0] C1 = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [127:0] C2 = {32'h0d, 32'h0c, 32'h0b, 32'h0a};
    localparam logic [127:0] CA = {32'ha3, 32'ha2, 32'ha1, 32'ha0};
    localparam logic [127:0] CB = {32'hb3, 32'hb2, 32'hb1, 32'hb0};
    localparam logic [127:0] CC = {32'hc3, 32'hc2, 32'hc1, 32'hc0};

    fir_mdc_job_sched #(
        .COEFF_W(32), .CNT_W(32), .QUEUE_DEPTH(2), .TIMEOUT(16)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .trig_i(trig_i),
        .trig_ready_o(trig_ready_o), .job_len_i(job_len_i), .job_coeff_i(job_coeff_i),
        .eng_coeff_o(eng_coeff_o), .eng_clear_o(eng_clear_o), .eng_start_o(eng_start_o),
        .eng_ready_i(eng_ready_i), .out_valid_i(out_valid_i), .out_ready_i(out_ready_i),
        .busy_o(busy_o), .evt_o(evt_o), .err_timeout_o(err_timeout_o),
        .beat_cnt_o(beat_cnt_o), .jobs_done_o(jobs_done_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic         trig;
        logic [31:0]  len;
        logic [127:0] coeff;
        logic         x_clr, x_st, x_evt, x_busy, x_trdy;
        logic [31:0]  x_beat, x_jobs;
        logic [127:0] x_coeff;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic trig, logic [31:0] len, logic [127:0] coeff,
                                logic clr, logic st, logic evt, logic busy, logic trdy,
                                logic [31:0] beat, logic [31:0] jobs, logic [127:0] xc);
        vec_t v;
        v.trig = trig; v.len = len; v.coeff = coeff;
        v.x_clr = clr; v.x_st = st; v.x_evt = evt; v.x_busy = busy; v.x_trdy = trdy;
        v.x_beat = beat; v.x_jobs = jobs; v.x_coeff = xc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1; clear_i = 1'b0; trig_i = 1'b0;
        job_len_i = 32'd0; job_coeff_i = 128'd0;
        step(); step();
        rst_i = 1'b0;
    endtask

    task automatic push(input logic [31:0] len, input logic [127:0] coeff);
        trig_i = 1'b1; job_len_i = len; job_coeff_i = coeff;
        step();
        trig_i = 1'b0;
    endtask

    task automatic run_to_beat(input logic [31:0] n, input string nm);
        for (int i = 0; i < 100; i++) begin
            if (beat_cnt_o == n) break;
            step();
        end
        chk(nm, beat_cnt_o, n);
    endtask

    task automatic wait_evt(input string nm);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (evt_o) begin
                seen = 1'b1;
                break;
            end
        end
        chk(nm, seen, 1'b1);
    endtask

    initial begin
        int   nevt, early, quiet;
        logic [31:0]  ev_beat [3];
        logic [127:0] ev_coeff [3];

        rst_i = 1'b1; clear_i = 1'b0; trig_i = 1'b0; job_len_i = 32'd0; job_coeff_i = 128'd0;
        eng_ready_i = 1'b0; out_valid_i = 1'b0; out_ready_i = 1'b0;
        #3;
        chk("rst trig_ready", trig_ready_o, 1'b1);
        chk("rst busy", busy_o, 1'b0);
        chk("rst evt", evt_o, 1'b0);
        chk("rst clr/start", {eng_clear_o, eng_start_o}, 2'b00);
        chk("rst err", err_timeout_o, 1'b0);
        chk("rst beat", beat_cnt_o, 32'd0);
        chk("rst jobs", jobs_done_o, 32'd0);
        chk("rst coeff", eng_coeff_o, 128'd0);
        do_reset();

        // cycle table: len=8 job with output always ready, then a len=0 job
        eng_ready_i = 1'b1; out_valid_i = 1'b1; out_ready_i = 1'b1;
        tbl.push_back(mk(1'b1, 32'd8, C1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, 128'd0));
        tbl.push_back(mk(1'b0, 32'd0, 128'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, C1));
        tbl.push_back(mk(1'b0, 32'd0, 128'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, C1));
        tbl.push_back(mk(1'b0, 32'd0, 128'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd0, C1));
        for (int b = 1; b <= 7; b++)
            tbl.push_back(mk(1'b0, 32'd0, 128'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'(b), 32'd0, C1));
        tbl.push_back(mk(1'b0, 32'd0, 128'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd8, 32'd1, C1));
        tbl.push_back(mk(1'b0, 32'd0, 128'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd8, 32'd1, C1));
        tbl.push_back(mk(1'b1, 32'd0, C2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'd8, 32'd1, C1));
        tbl.push_back(mk(1'b0, 32'd0, 128'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'd0, 32'd1, C2));
        tbl.push_back(mk(1'b0, 32'd0, 128'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'd0, 32'd2, C2));
        tbl.push_back(mk(1'b0, 32'd0, 128'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 32'd2, C2));
        foreach (tbl[i]) begin
            trig_i = tbl[i].trig; job_len_i = tbl[i].len; job_coeff_i = tbl[i].coeff;
            step();
            chk($sformatf("tbl%0d clr", i), eng_clear_o, tbl[i].x_clr);
            chk($sformatf("tbl%0d start", i), eng_start_o, tbl[i].x_st);
            chk($sformatf("tbl%0d evt", i), evt_o, tbl[i].x_evt);
            chk($sformatf("tbl%0d busy", i), busy_o, tbl[i].x_busy);
            chk($sformatf("tbl%0d trig_ready", i), trig_ready_o, tbl[i].x_trdy);
            chk($sformatf("tbl%0d beat", i), beat_cnt_o, tbl[i].x_beat);
            chk($sformatf("tbl%0d jobs", i), jobs_done_o, tbl[i].x_jobs);
            chk($sformatf("tbl%0d coeff", i), eng_coeff_o, tbl[i].x_coeff);
        end
        trig_i = 1'b0;

        // queue fill with the engine busy: third push must wait for the first pop
        do_reset();
        eng_ready_i = 1'b0;
        trig_i = 1'b1; job_len_i = 32'd4; job_coeff_i = CA; step();
        chk("q one entry ready", trig_ready_o, 1'b1);
        job_len_i = 32'd5; job_coeff_i = CB; step();
        chk("q full ready", trig_ready_o, 1'b0);
        job_len_i = 32'd6; job_coeff_i = CC; step();
        chk("q blocked ready", trig_ready_o, 1'b0);
        chk("q blocked busy", busy_o, 1'b1);
        eng_ready_i = 1'b1; step();
        chk("q ready after pop", trig_ready_o, 1'b1);
        chk("q first load clr", eng_clear_o, 1'b1);
        step();
        trig_i = 1'b0;
        nevt = 0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (evt_o) begin
                ev_beat[nevt] = beat_cnt_o;
                ev_coeff[nevt] = eng_coeff_o;
                nevt++;
                if (nevt == 3) break;
            end
        end
        chk("q evt count", nevt, 3);
        chk("q job0 len", ev_beat[0], 32'd4);
        chk("q job1 len", ev_beat[1], 32'd5);
        chk("q job2 len", ev_beat[2], 32'd6);
        chk("q job0 coeff", ev_coeff[0], CA);
        chk("q job1 coeff", ev_coeff[1], CB);
        chk("q job2 coeff", ev_coeff[2], CC);
        for (int i = 0; i < 40; i++) step();
        chk("q jobs done", jobs_done_o, 32'd3);
        chk("q idle busy", busy_o, 1'b0);

        // handshake on the last watchdog cycle restarts the watchdog
        do_reset();
        eng_ready_i = 1'b1; out_valid_i = 1'b1; out_ready_i = 1'b1;
        push(32'd3, CA);
        run_to_beat(32'd1, "wd reach beat1");
        early = 0;
        out_ready_i = 1'b0;
        for (int i = 0; i < 15; i++) begin step(); early += int'(evt_o); end
        out_ready_i = 1'b1; step();
        chk("wd edge beat", beat_cnt_o, 32'd2);
        chk("wd edge err", err_timeout_o, 1'b0);
        out_ready_i = 1'b0;
        for (int i = 0; i < 15; i++) begin step(); early += int'(evt_o); end
        out_ready_i = 1'b1; step();
        chk("wd no abort evts", early, 0);
        chk("wd done evt", evt_o, 1'b1);
        chk("wd done beat", beat_cnt_o, 32'd3);
        chk("wd done err", err_timeout_o, 1'b0);
        chk("wd done jobs", jobs_done_o, 32'd1);

        // output stall aborts after 16 idle cycles; the queued job then completes
        do_reset();
        push(32'd10, CA);
        push(32'd2, CB);
        run_to_beat(32'd3, "stall reach beat3");
        out_ready_i = 1'b0;
        early = 0;
        for (int i = 0; i < 15; i++) begin step(); early += int'(evt_o); end
        chk("stall no early evt", early, 0);
        step();
        chk("abort evt", evt_o, 1'b1);
        chk("abort clr", eng_clear_o, 1'b1);
        chk("abort err", err_timeout_o, 1'b1);
        chk("abort beat", beat_cnt_o, 32'd3);
        chk("abort jobs", jobs_done_o, 32'd0);
        out_ready_i = 1'b1;
        wait_evt("next job evt");
        chk("next job beat", beat_cnt_o, 32'd2);
        chk("next job coeff", eng_coeff_o, CB);
        chk("next job jobs", jobs_done_o, 32'd1);
        chk("err sticky", err_timeout_o, 1'b1);

        // soft clear mid-run with a job queued and a concurrent push
        step(); step();
        push(32'd10, CA);
        push(32'd5, CB);
        run_to_beat(32'd4, "clr reach beat4");
        clear_i = 1'b1; trig_i = 1'b1; job_len_i = 32'd7; job_coeff_i = CC;
        #1;
        chk("clr eng_clear same cycle", eng_clear_o, 1'b1);
        step();
        clear_i = 1'b0; trig_i = 1'b0;
        chk("clr beat", beat_cnt_o, 32'd0);
        chk("clr jobs", jobs_done_o, 32'd0);
        chk("clr err", err_timeout_o, 1'b0);
        chk("clr coeff", eng_coeff_o, 128'd0);
        chk("clr trig_ready", trig_ready_o, 1'b1);
        chk("clr evt", evt_o, 1'b0);
        quiet = 0;
        for (int i = 0; i < 10; i++) begin step(); quiet += int'(evt_o) + int'(busy_o); end
        chk("clr stays idle", quiet, 0);

        // async reset in the middle of a job
        push(32'd1, CA);
        wait_evt("pre-rst job evt");
        chk("pre-rst jobs", jobs_done_o, 32'd1);
        push(32'd10, CB);
        run_to_beat(32'd2, "rst reach beat2");
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst beat", beat_cnt_o, 32'd0);
        chk("arst jobs", jobs_done_o, 32'd0);
        chk("arst busy", busy_o, 1'b0);
        chk("arst trig_ready", trig_ready_o, 1'b1);
        chk("arst coeff", eng_coeff_o, 128'd0);
        chk("arst pulses", {evt_o, eng_clear_o, eng_start_o}, 3'b000);
        step();
        rst_i = 1'b0;
        quiet = 0;
        for (int i = 0; i < 10; i++) begin step(); quiet += int'(evt_o) + int'(busy_o); end
        chk("arst stays idle", quiet, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
